// File: rtl/game_nxn.sv
// N x N tic-tac-toe controller with K-in-a-row win detection and a sequential
// win walker. Define GAME_FLASH_O_EN to make O cells flash on occ_pos.
module game_nxn #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flash_clk,
  input  logic [N*N-1:0] sel_pos,
  input  logic           buttonX,
  input  logic           buttonO,
  output logic           turnX,
  output logic           turnO,
  output logic [N*N-1:0] occ_pos,
  output logic [7:0]     game_st
);
  localparam int NC = N * N;
  localparam int MW = $clog2(NC + 1);
  localparam int IW = $clog2(NC);
  localparam logic [7:0] CH_PLAY = 8'h2D;
  localparam logic [7:0] CH_X    = 8'h58;
  localparam logic [7:0] CH_O    = 8'h4F;
  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_E    = 8'h45;

  typedef enum logic [2:0] {PLAY_X, PLAY_O, CHECK, DONE, ERR} state_t;
  state_t state_q, state_d;

  logic [NC-1:0] occ_q, own_q;
  logic [MW-1:0] mcnt_q;
  logic [3:0]    row_q, col_q;
  logic          mover_o_q;
  logic [7:0]    res_q, res_d;
  logic          buttonX_q, buttonO_q;
  logic          press_x, press_o, move_ok;

  // walker state: direction, side (+/-), step along side, run count
  logic [1:0] dir_q;
  logic       side_q;
  logic [2:0] step_q;
  logic [3:0] cnt_q;
  logic       ok_q, win_q;

  assign press_x = buttonX & ~buttonX_q;
  assign press_o = buttonO & ~buttonO_q;

  logic [3:0] sel_r, sel_c;
  always_comb begin
    sel_r = '0;
    sel_c = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (sel_pos[r*N+c]) begin
          sel_r = 4'(r);
          sel_c = 4'(c);
        end
  end

  // Cell under the walker and its contribution to the current run
  logic [7:0]    off, dr, dc, wr, wc;
  logic [IW-1:0] cidx;
  logic          in_b, hit, base_ok, ok_d, last_step, last_cell, win_d;
  logic [3:0]    base_cnt, cnt_d;
  always_comb begin
    off = 8'(step_q) + 8'd1;
    dr  = (dir_q == 2'd0) ? 8'd0 : off;
    unique case (dir_q)
      2'd0:    dc = off;
      2'd1:    dc = 8'd0;
      2'd2:    dc = off;
      default: dc = 8'd0 - off;
    endcase
    if (side_q) begin
      dr = 8'd0 - dr;
      dc = 8'd0 - dc;
    end
    wr   = {4'd0, row_q} + dr;
    wc   = {4'd0, col_q} + dc;
    in_b = !wr[7] && !wc[7] && (wr < 8'(N)) && (wc < 8'(N));
    cidx = in_b ? IW'(wr * 8'(N) + wc) : '0;
    hit  = in_b && occ_q[cidx] && (own_q[cidx] == mover_o_q);
    last_step = (step_q == 3'(K - 2));
    last_cell = last_step && side_q && (dir_q == 2'd3);
    // a miss stops counting on this side but the walk keeps a fixed length
    base_ok  = (step_q == 3'd0) ? 1'b1 : ok_q;
    base_cnt = (step_q == 3'd0 && !side_q) ? 4'd1 : cnt_q;
    ok_d     = base_ok && hit;
    cnt_d    = base_cnt + {3'd0, ok_d};
    win_d    = win_q || (last_step && side_q && (cnt_d >= 4'(K)));
  end

  always_comb begin
    state_d = state_q;
    move_ok = 1'b0;
    res_d   = res_q;
    unique case (state_q)
      PLAY_X, PLAY_O: begin
        if (press_x || press_o) begin
          if ((press_x && press_o) || ((state_q == PLAY_O) ? press_x : press_o) ||
              !$onehot(sel_pos) || (|(sel_pos & occ_q)))
            state_d = ERR;
          else begin
            state_d = CHECK;
            move_ok = 1'b1;
          end
        end
      end
      CHECK: begin
        if (press_x || press_o)
          state_d = ERR;
        else if (last_cell) begin
          if (win_d) begin
            state_d = DONE;
            res_d   = mover_o_q ? CH_O : CH_X;
          end else if (mcnt_q == MW'(NC)) begin
            state_d = DONE;
            res_d   = CH_C;
          end else
            state_d = mover_o_q ? PLAY_X : PLAY_O;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PLAY_X;
      occ_q     <= '0;
      own_q     <= '0;
      mcnt_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      mover_o_q <= 1'b0;
      res_q     <= CH_PLAY;
      buttonX_q <= 1'b0;
      buttonO_q <= 1'b0;
      dir_q     <= '0;
      side_q    <= 1'b0;
      step_q    <= '0;
      cnt_q     <= 4'd1;
      ok_q      <= 1'b1;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      buttonX_q <= buttonX;
      buttonO_q <= buttonO;
      if (move_ok) begin
        occ_q     <= occ_q | sel_pos;
        if (state_q == PLAY_O) own_q <= own_q | sel_pos;
        row_q     <= sel_r;
        col_q     <= sel_c;
        mover_o_q <= (state_q == PLAY_O);
        mcnt_q    <= mcnt_q + 1'b1;
        dir_q     <= '0;
        side_q    <= 1'b0;
        step_q    <= '0;
        cnt_q     <= 4'd1;
        ok_q      <= 1'b1;
        win_q     <= 1'b0;
      end else if (state_q == CHECK) begin
        cnt_q <= cnt_d;
        ok_q  <= ok_d;
        win_q <= win_d;
        if (last_step) begin
          step_q <= '0;
          side_q <= ~side_q;
          if (side_q) dir_q <= dir_q + 2'd1;
        end else
          step_q <= step_q + 3'd1;
      end
    end
  end

  assign turnX = (state_q == PLAY_X);
  assign turnO = (state_q == PLAY_O);

  always_comb begin
    unique case (state_q)
      DONE:    game_st = res_q;
      ERR:     game_st = CH_E;
      default: game_st = CH_PLAY;
    endcase
  end

`ifdef GAME_FLASH_O_EN
  // two-stage sample of the slow flash input; phase toggles on its rise
  logic flash_s1, flash_s2, phase;
  always_ff @(posedge clk) begin
    if (reset) begin
      flash_s1 <= 1'b0;
      flash_s2 <= 1'b0;
      phase    <= 1'b0;
    end else begin
      flash_s1 <= flash_clk;
      flash_s2 <= flash_s1;
      if (flash_s1 && !flash_s2) phase <= ~phase;
    end
  end
  assign occ_pos = occ_q & (~own_q | {NC{phase}});
`else
  logic unused_flash;
  assign unused_flash = flash_clk;
  assign occ_pos = occ_q;
`endif

endmodule

// File: tb/tb_game_nxn.sv
// Self-checking bench for game_nxn: 3x3/K=3 and 5x5/K=4 instances against a
// board-level reference model (full-line scan for wins).
module tb_game_nxn;
`ifdef GAME_FLASH_O_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, flash_clk;
  logic [8:0]  sel_pos, occ_pos;
  logic        buttonX, buttonO, turnX, turnO;
  logic [7:0]  game_st;
  logic [24:0] sel5, occ5;
  logic        bx5, bo5, tx5, to5;
  logic [7:0]  st5;

  int checks = 0, errors = 0;

  // reference model
  int   mb[64];
  int   m_mode;      // 0 playing, 2 done, 3 error
  bit   m_chk, m_turn_o, m_phase, fs1, fs2;
  int   m_moves;
  logic [7:0] m_res;

  always #5 clk = ~clk;

  game_nxn #(.N(3), .K(3)) dut (
    .clk(clk), .reset(reset), .flash_clk(flash_clk), .sel_pos(sel_pos),
    .buttonX(buttonX), .buttonO(buttonO), .turnX(turnX), .turnO(turnO),
    .occ_pos(occ_pos), .game_st(game_st));

  game_nxn #(.N(5), .K(4)) dut5 (
    .clk(clk), .reset(reset), .flash_clk(flash_clk), .sel_pos(sel5),
    .buttonX(bx5), .buttonO(bo5), .turnX(tx5), .turnO(to5),
    .occ_pos(occ5), .game_st(st5));

  function automatic bit m_win(int n, int k, int p);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          int dr, dc;
          bit all;
          dr = (d == 0) ? 0 : 1;
          dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
          all = 1'b1;
          for (int i = 0; i < k; i++) begin
            int rr, cc;
            rr = r + dr * i;
            cc = c + dc * i;
            if (rr < 0 || rr >= n || cc < 0 || cc >= n) all = 1'b0;
            else if (mb[rr*n+cc] != p) all = 1'b0;
          end
          if (all) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_occ(int n);
    logic [63:0] e;
    e = '0;
    for (int i = 0; i < n * n; i++)
      e[i] = (mb[i] == 1) || (mb[i] == 2 && (!FLASH || m_phase));
    return e;
  endfunction

  function automatic logic [7:0] exp_st();
    return (m_mode == 3) ? 8'h45 : (m_mode == 2) ? m_res : 8'h2D;
  endfunction

  task automatic step();
    bit cur, rst;
    cur = flash_clk;
    rst = reset;
    @(posedge clk); #1;
    if (rst) begin
      fs1 = 0; fs2 = 0; m_phase = 0;
    end else begin
      if (fs1 && !fs2) m_phase = !m_phase;
      fs2 = fs1;
      fs1 = cur;
    end
  endtask

  task automatic do_reset();
    reset = 1; flash_clk = 0; buttonX = 0; buttonO = 0; bx5 = 0; bo5 = 0;
    sel_pos = '0; sel5 = '0;
    repeat (3) step();
    reset = 0;
    for (int i = 0; i < 64; i++) mb[i] = 0;
    m_mode = 0; m_chk = 0; m_turn_o = 0; m_moves = 0; m_res = 8'h2D;
  endtask

  task automatic sample(input bit big, output logic [63:0] o, output logic [7:0] s,
                        output logic tx, output logic to);
    o = '0;
    if (big) begin o[24:0] = occ5; s = st5; tx = tx5; to = to5; end
    else begin o[8:0] = occ_pos; s = game_st; tx = turnX; to = turnO; end
  endtask

  // one-cycle press, then release; updates the model
  task automatic press(input bit big, input bit px, input bit po, input logic [63:0] sel);
    int n, idx;
    n = big ? 5 : 3;
    if (big) begin sel5 = sel[24:0]; bx5 = px; bo5 = po; end
    else begin sel_pos = sel[8:0]; buttonX = px; buttonO = po; end
    step();
    buttonX = 0; buttonO = 0; bx5 = 0; bo5 = 0;
    idx = 0;
    for (int i = 0; i < n * n; i++) if (sel[i]) idx = i;
    if (m_chk) begin
      m_mode = 3; m_chk = 0;
    end else if (m_mode == 0) begin
      if ((px && po) || (m_turn_o ? px : po) || $countones(sel) != 1 || mb[idx] != 0)
        m_mode = 3;
      else begin
        mb[idx] = m_turn_o ? 2 : 1; m_moves++; m_chk = 1;
      end
    end
  endtask

  task automatic finish_check(input bit big);
    int n, k;
    n = big ? 5 : 3;
    k = big ? 4 : 3;
    m_chk = 0;
    if (m_win(n, k, m_turn_o ? 2 : 1)) begin
      m_mode = 2; m_res = m_turn_o ? 8'h4F : 8'h58;
    end else if (m_moves == n * n) begin
      m_mode = 2; m_res = 8'h43;
    end else
      m_turn_o = !m_turn_o;
  endtask

  task automatic test_game(input string name, input bit big, input int cells[$],
                           input logic [7:0] want);
    int chk;
    logic [63:0] e, o;
    logic [7:0] s;
    logic tx, to;
    chk = big ? 24 : 16;
    do_reset();
    foreach (cells[j]) begin
      if (m_mode != 0) break;
      press(big, !m_turn_o, m_turn_o, 64'd1 << cells[j]);
      sample(big, o, s, tx, to);
      e = exp_occ(big ? 5 : 3);
      checks++;
      if (o !== e || tx !== 1'b0 || to !== 1'b0 || s !== 8'h2D) begin
        errors++;
        $display("FAIL %s move%0d start: occ=%h st=%h tx=%b to=%b want occ=%h st=2d turns 0",
                 name, j, o, s, tx, to, e);
      end
      repeat (chk - 1) step();
      sample(big, o, s, tx, to);
      checks++;
      if (tx !== 1'b0 || to !== 1'b0 || s !== 8'h2D) begin
        errors++;
        $display("FAIL %s move%0d last check cycle: st=%h tx=%b to=%b want st=2d turns 0",
                 name, j, s, tx, to);
      end
      step();
      finish_check(big);
      sample(big, o, s, tx, to);
      checks++;
      if (s !== exp_st() || tx !== (m_mode == 0 && !m_turn_o) || to !== (m_mode == 0 && m_turn_o)) begin
        errors++;
        $display("FAIL %s move%0d result: st=%h tx=%b to=%b want st=%h turnO=%b mode=%0d",
                 name, j, s, tx, to, exp_st(), m_turn_o, m_mode);
      end
    end
    if (want != 8'h00) begin
      sample(big, o, s, tx, to);
      checks++;
      if (s !== want) begin
        errors++;
        $display("FAIL %s final status: got %h want %h", name, s, want);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (occ_pos !== 9'h000 || game_st !== 8'h2D || turnX !== 1'b1 || turnO !== 1'b0 ||
        occ5 !== 25'h0 || st5 !== 8'h2D || tx5 !== 1'b1 || to5 !== 1'b0) begin
      errors++;
      $display("FAIL reset: occ=%h st=%h tx=%b to=%b st5=%h want 000 2d 1 0", occ_pos, game_st, turnX, turnO, st5);
    end
  endtask

  task automatic test_mid_check_reset();
    do_reset();
    press(0, 1, 0, 64'h10);
    repeat (7) step();
    reset = 1;
    step();
    checks++;
    if (occ_pos !== 9'h000 || game_st !== 8'h2D || turnX !== 1'b1 || turnO !== 1'b0) begin
      errors++;
      $display("FAIL mid_check_reset: occ=%h st=%h tx=%b to=%b want 000 2d 1 0", occ_pos, game_st, turnX, turnO);
    end
    reset = 0;
  endtask

  task automatic test_err_first();
    do_reset();
    press(0, 0, 1, 64'h1);
    checks++;
    if (game_st !== 8'h45 || turnX !== 1'b0 || turnO !== 1'b0) begin
      errors++;
      $display("FAIL wrong_first: st=%h tx=%b to=%b want 45 0 0", game_st, turnX, turnO);
    end
    step();
    press(0, 1, 0, 64'h1);
    step();
    checks++;
    if (game_st !== 8'h45 || occ_pos !== 9'h000) begin
      errors++;
      $display("FAIL err_sticky: st=%h occ=%h want 45 000", game_st, occ_pos);
    end
  endtask

  task automatic test_errors();
    logic [63:0] e;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      case (i)
        0: begin
          press(0, 1, 0, 64'h10);
          repeat (16) step();
          finish_check(0);
          press(0, 0, 1, 64'h10);
        end
        1: press(0, 1, 0, 64'h3);
        2: press(0, 1, 1, 64'h1);
        default: begin
          press(0, 1, 0, 64'h1);
          repeat (5) step();
          press(0, 0, 1, 64'h100);
        end
      endcase
      e = exp_occ(3);
      checks++;
      if (game_st !== 8'h45 || turnX !== 1'b0 || turnO !== 1'b0 || occ_pos !== e[8:0]) begin
        errors++;
        $display("FAIL error_case%0d: st=%h tx=%b to=%b occ=%h want 45 0 0 %h",
                 i, game_st, turnX, turnO, occ_pos, e[8:0]);
      end
    end
  endtask

  task automatic test_held();
    do_reset();
    sel_pos = 9'h001; buttonX = 1;
    step();
    mb[0] = 1; m_moves = 1; m_chk = 1;
    repeat (16) step();
    finish_check(0);
    sel_pos = 9'h002;
    repeat (3) step();
    checks++;
    if (turnO !== 1'b1 || turnX !== 1'b0 || game_st !== 8'h2D || occ_pos !== 9'h001) begin
      errors++;
      $display("FAIL held_button: tx=%b to=%b st=%h occ=%h want 0 1 2d 001", turnX, turnO, game_st, occ_pos);
    end
    buttonX = 0;
  endtask

  task automatic test_flash();
    logic [63:0] e;
    do_reset();
    press(0, 1, 0, 64'h1);
    repeat (16) step();
    finish_check(0);
    press(0, 0, 1, 64'h2);
    repeat (16) step();
    finish_check(0);
    for (int c = 0; c < 48; c++) begin
      flash_clk = ((c / 4) % 2) == 1;
      step();
      e = exp_occ(3);
      checks++;
      if (occ_pos !== e[8:0]) begin
        errors++;
        $display("FAIL flash cycle%0d: occ=%h want %h", c, occ_pos, e[8:0]);
      end
    end
    flash_clk = 0;
  endtask

  task automatic test_random();
    int q[$];
    int j, t;
    for (int g = 0; g < 4; g++) begin
      q = {0, 1, 2, 3, 4, 5, 6, 7, 8};
      for (int i = 8; i > 0; i--) begin
        j = $urandom_range(i, 0); t = q[i]; q[i] = q[j]; q[j] = t;
      end
      test_game("random3", 0, q, 8'h00);
    end
    q = {};
    for (int i = 0; i < 25; i++) q.push_back(i);
    for (int i = 24; i > 0; i--) begin
      j = $urandom_range(i, 0); t = q[i]; q[i] = q[j]; q[j] = t;
    end
    test_game("random5", 1, q, 8'h00);
  endtask

  initial begin
    int q[$];
    test_reset();
    q = {0, 3, 1, 4, 2};
    test_game("x_wins", 0, q, 8'h58);
    checks++;
    if (occ_pos !== (FLASH ? 9'h007 : 9'h01F) || turnX !== 1'b0 || turnO !== 1'b0) begin
      errors++;
      $display("FAIL x_wins board: occ=%h tx=%b to=%b", occ_pos, turnX, turnO);
    end
    test_mid_check_reset();
    test_err_first();
    test_errors();
    q = {0, 1, 2, 4, 3, 5, 7, 6, 8};
    test_game("cat", 0, q, 8'h43);
    test_held();
    q = {3, 0, 7, 1, 11, 5, 15};
    test_game("anti_diag_5x5", 1, q, 8'h58);
    test_random();
    test_flash();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_nxn.md
# game_nxn

Parametrised tic-tac-toe game controller: an N×N board, K-in-a-row win rule, two players (X moves first), sticky error detection and ASCII game status. It sits between the push-button/position-select front panel and the LED/character display. It extends the fixed 3×3 controller with a sequential win checker that walks only the lines through the last placed cell, so area scales with N, not with the number of lines.

## Interface
- `N`, default 3: board dimension; legal range 3..8.
- `K`, default 3: marks in a row needed to win; legal range 2..N.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; game held in reset while 1.
- `flash_clk`  in  1  slow square wave, sampled as data in the `clk` domain (not a clock).
- `sel_pos`  in  N*N  selected cell, one-hot; bit r*N+c, bit 0 = top-left.
- `buttonX`  in  1  X player's place button (level; edge-detected internally).
- `buttonO`  in  1  O player's place button (level; edge-detected internally).
- `turnX`  out  1  it is X's turn and a move is accepted.
- `turnO`  out  1  it is O's turn and a move is accepted.
- `occ_pos`  out  N*N  per-cell LED: 0 = empty, 1 = X, flashing = O.
- `game_st`  out  8  ASCII status: `-` 0x2D playing, `X` 0x58, `O` 0x4F, `C` 0x43, `E` 0x45.

## Operation
- Internal board: `occ[N*N]` and `own[N*N]` (own = 1 for O). Move counter: ceil(log2(N*N+1)) bits.
- Press detection: `pressX = buttonX & ~buttonX_q`, and likewise for O. Both `_q` registers clear on reset.
- States:
  - PLAY_X and PLAY_O: `turnX`/`turnO` high respectively.
  - CHECK: both turn outputs low.
  - DONE: status X/O/C.
  - ERR: status E.
- Move in PLAY_p (one or more presses in a cycle):
  - Error if any of: both presses; press by the non-turn player; `sel_pos` not exactly one-hot; selected cell occupied. Error → ERR.
  - Otherwise: set occ/own of the cell, record its row/column, increment the move count, → CHECK.
- Any press during CHECK is a wrong-turn error → ERR.
- Presses in DONE or ERR are ignored. ERR and DONE exit only via `reset`.
- CHECK walker:
  - Directions in order: (0,+1), (+1,0), (+1,+1), (+1,−1).
  - For each direction: walk the + side for K−1 steps, then the − side for K−1 steps, one cell per cycle.
  - The run count starts at 1 and increments while cells are in-board, occupied, and owned by the mover. Counting stops at the first miss on that side; the walk continues so duration stays fixed.
  - Win flag sets if any direction's count ≥ K.
- End of CHECK:
  - Win → DONE, status = mover.
  - Else move count = N*N → DONE, status C.
  - Else → PLAY of the other player.
- Flash: a rising edge of sampled `flash_clk` toggles `phase`. `occ_pos[i] = occ[i] & (~own[i] | phase)`.

## Timing
- Reset values:
  - `occ_pos` = 0, `game_st` = 0x2D, `turnX` = 1, `turnO` = 0.
  - Board, move count, `phase`, and walker all cleared; state PLAY_X.
- Press sampled at edge t (button 1 at t, 0 at t−1):
  - Board and `occ_pos` update at t+1; state is CHECK from t+1.
  - CHECK lasts exactly 8*(K−1) cycles. The next state and the `turnX`/`turnO`/`game_st` update are visible at t+1+8*(K−1). For N=K=3 this is t+17.
- Error: `game_st` = 0x45 at t+1; turn outputs low from t+1. The board is unchanged by the erroneous move.
- `reset` asserted in any state, including mid-CHECK, returns all reset values at the next edge.
- A button held across a turn change generates no new press.
- `phase` toggles 1 cycle after the sampled `flash_clk` rising edge, so an O LED has period 2× that of `flash_clk`.

## Configuration
- `GAME_FLASH_O_EN` defined: O cells flash as described.
- `GAME_FLASH_O_EN` undefined: `occ_pos = occ` (O shown steady). `flash_clk` is unused and the phase logic is removed. All other behaviour is identical.

## Test plan
All scenarios use N=3, K=3 unless stated.
- Reset held 3 cycles → `occ_pos` 0x000, `game_st` 0x2D, `turnX` 1, `turnO` 0. Assert reset mid-CHECK → same values next cycle.
- Moves X0, O3, X1, O4, X2 → 17 cycles after the final press, `game_st` 0x58; `turnX` = `turnO` = 0; `occ` 0x01F.
- First press is buttonO with `sel_pos` 0x001 → `game_st` 0x45 next cycle. Further presses are ignored until reset.
- Separate error checks, each → 0x45: X at cell 4 then O at cell 4; `sel_pos` 0x003; buttonX and buttonO pressed in the same cycle; press during CHECK.
- Moves X0, O1, X2, O4, X3, O5, X7, O6, X8 → `game_st` 0x43 after the last CHECK.
- With `GAME_FLASH_O_EN`, an O at cell 1 and `flash_clk` period 8 cycles → `occ_pos[1]` has period 16. N=5, K=4: X wins on the anti-diagonal cells 3, 7, 11, 15 after 24 CHECK cycles.
